// File: rtl/uart_xmtr.sv
// UART transmitter: holds one byte, then serializes start, data (LSB first),
// optional even parity and stop bit(s), each held samples_per_bit clocks.
module uart_xmtr #(
    parameter int word_size       = 8,
    parameter int samples_per_bit = 8,
    parameter int parity_en       = 0,
    parameter int stop_bits       = 1
) (
    input  logic                 Sample_clk,
    input  logic                 rst,
    input  logic [word_size-1:0] Data_bus,
    input  logic                 Load_XMT_datareg,
    input  logic                 Byte_ready,
    output logic                 Serial_out,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Load_err
);

    localparam int frame_len = 1 + word_size + parity_en + stop_bits;
    localparam int scw       = (samples_per_bit > 1) ? $clog2(samples_per_bit) : 1;
    localparam logic [scw-1:0] sample_last = scw'(samples_per_bit - 1);
    localparam logic [3:0]     bit_last    = 4'(frame_len - 1);

    // Handshake: a load is accepted in IDLE/WAITING and wins over Byte_ready in
    // the same cycle; Byte_ready only starts a frame from WAITING with no load.
    typedef enum logic [1:0] {IDLE, WAITING, SENDING} state_t;

    state_t                 state, state_next;
    logic [word_size-1:0]   XMT_datareg;
    logic [frame_len-1:0]   shift_reg;
    logic [frame_len-1:0]   frame_word;
    logic [scw-1:0]         Sample_counter;
    logic [3:0]             Bit_counter;
    logic                   load_hold, start_frame, bit_end, frame_end, load_reject;

    always_ff @(posedge Sample_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Load_XMT_datareg) state_next = WAITING;
            WAITING: if (!Load_XMT_datareg && Byte_ready) state_next = SENDING;
            SENDING: if (frame_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_hold   = Load_XMT_datareg && (state != SENDING);
        start_frame = (state == WAITING) && Byte_ready && !Load_XMT_datareg;
        bit_end     = (state == SENDING) && (Sample_counter == sample_last);
        frame_end   = bit_end && (Bit_counter == bit_last);
        load_reject = (state == SENDING) && Load_XMT_datareg;
    end

    // Frame image, bit 0 goes out first; unused upper bits are stop bits.
    always_comb begin
        frame_word              = '1;
        frame_word[0]           = 1'b0;
        frame_word[word_size:1] = XMT_datareg;
        if (parity_en != 0) frame_word[word_size+1] = ^XMT_datareg;
    end

    always_ff @(posedge Sample_clk or posedge rst) begin
        if (rst) begin
            XMT_datareg    <= '0;
            shift_reg      <= '1;
            Sample_counter <= '0;
            Bit_counter    <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            Load_err       <= 1'b0;
        end else begin
            Done     <= frame_end;
            Load_err <= load_reject;
            if (load_hold) XMT_datareg <= Data_bus;
            if (start_frame) begin
                shift_reg      <= frame_word;
                Sample_counter <= '0;
                Bit_counter    <= '0;
                Busy           <= 1'b1;
            end else if (state == SENDING) begin
                if (bit_end) begin
                    Sample_counter <= '0;
                    shift_reg      <= {1'b1, shift_reg[frame_len-1:1]};
                    if (frame_end) Busy <= 1'b0;
                    else           Bit_counter <= Bit_counter + 4'd1;
                end else begin
                    Sample_counter <= Sample_counter + 1'b1;
                end
            end
        end
    end

    // The line is the shift register's low flop; reset preloads ones so it idles high.
    assign Serial_out = shift_reg[0];

endmodule
